// File: rtl/cond_logic.sv
// ARM conditional-execution stage: evaluates Cond against the registered NZCV flags and gates the decoder write strobes.
// Enables are combinational (0 cycles); Flags and the debug counters update one cycle later.
module cond_logic #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];

  // Decode always uses the architectural flags so a flag-setting
  // instruction only influences the instruction after it.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx   = cond_pass & InstrValid;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & !NoWrite;
  assign MemWrite = MemW & CondEx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags     <= 4'b0000;
      ExecCount <= '0;
      SkipCount <= '0;
    end else begin
      if (FlagW[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
      if (InstrValid) begin
        if (CondEx) ExecCount <= ExecCount + CNT_W'(1);
        else        SkipCount <= SkipCount + CNT_W'(1);
      end
    end
  end

endmodule
